// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, cause codes, bit positions, op encodings and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIE_MTIE_BIT     = 7;

  // funct3[1:0]; 2'b00 is not a CSR access
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {RUN, WFI, TRAP, MRET} trap_state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap sequencer: CSR read/modify/write,
// interrupt entry, MRET exit and WFI sleep with PC redirect and flush.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_read,
  input  logic            csr_write,
  input  logic [1:0]      csr_imm_sel,
  input  logic            flag_mret,
  input  logic            wfi_stall,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            instr_retire,
  input  logic            stall_in,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            interrupt,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            pipe_stall
);

  trap_state_e     state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            meie_q, meie_d;
  logic            mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle, minstret;

  logic            irq_pending;
  logic [XLEN-1:0] csr_old, csr_new;
  logic            csr_we, take_trap, take_mret;
  logic [XLEN-1:0] trap_epc;

  // Operand selection already happened upstream; only the op bits matter here.
  logic unused_bits;
  assign unused_bits = ^{csr_imm_sel, funct3[2], trap_epc[1:0]};

  assign irq_pending = (ext_irq & meie_q) | (timer_irq & mtie_q);
  assign interrupt   = irq_pending;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_old[MSTATUS_MIE_BIT]                     = mie_q;
        csr_old[MSTATUS_MPIE_BIT]                    = mpie_q;
        csr_old[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]     = 2'b11;
      end
      CSR_MIE: begin
        csr_old[MIE_MEIE_BIT] = meie_q;
        csr_old[MIE_MTIE_BIT] = mtie_q;
      end
      CSR_MTVEC:     csr_old = mtvec_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MIP: begin
        csr_old[MIE_MEIE_BIT] = ext_irq;
        csr_old[MIE_MTIE_BIT] = timer_irq;
      end
      CSR_MCYCLE:    csr_old = XLEN'(mcycle[31:0]);
      CSR_MCYCLEH:   csr_old = XLEN'(mcycle[63:32]);
      CSR_MINSTRET:  csr_old = XLEN'(minstret[31:0]);
      CSR_MINSTRETH: csr_old = XLEN'(minstret[63:32]);
      default:       csr_old = '0;
    endcase
  end

  assign csr_rdata = csr_read ? csr_old : '0;

  always_comb begin
    case (funct3[1:0])
      CSR_OP_WRITE: csr_new = csr_wdata;
      CSR_OP_SET:   csr_new = csr_old | csr_wdata;
      CSR_OP_CLEAR: csr_new = csr_old & ~csr_wdata;
      default:      csr_new = csr_old;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    take_trap   = 1'b0;
    take_mret   = 1'b0;
    trap_epc    = pc_ex;
    redirect    = 1'b0;
    flush       = 1'b0;
    redirect_pc = mtvec_q;
    pipe_stall  = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall_in) begin
          if (irq_pending && mie_q && !flag_mret) begin
            take_trap = 1'b1;
            state_d   = TRAP;
          end else if (flag_mret) begin
            take_mret = 1'b1;
            state_d   = MRET;
          end else if (wfi_stall) begin
            state_d = WFI;
          end
        end
      end
      WFI: begin
        pipe_stall = 1'b1;
        if (irq_pending) begin
          if (mie_q) begin
            // The WFI itself has completed, so return past it.
            take_trap = 1'b1;
            trap_epc  = pc_ex + XLEN'(4);
            state_d   = TRAP;
          end else begin
            state_d = RUN;
          end
        end
      end
      TRAP: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = mtvec_q;
        state_d     = RUN;
      end
      MRET: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = mepc_q;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign csr_we = csr_write && (funct3[1:0] != 2'b00) && (state_q == RUN)
                  && !stall_in && !take_trap;

  // Trap entry and MRET override a same-cycle software write to mstatus.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtie_d   = mtie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_new[MSTATUS_MIE_BIT];
          mpie_d = csr_new[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          meie_d = csr_new[MIE_MEIE_BIT];
          mtie_d = csr_new[MIE_MTIE_BIT];
        end
        CSR_MTVEC:  mtvec_d  = {csr_new[XLEN-1:2], 2'b00};
        CSR_MEPC:   mepc_d   = {csr_new[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_new;
        default: ;
      endcase
    end
    if (take_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (take_trap) begin
      mepc_d   = {trap_epc[XLEN-1:2], 2'b00};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = {1'b1, {(XLEN-5){1'b0}},
                  (ext_irq && meie_q) ? CAUSE_MEI : CAUSE_MTI};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtvec_q  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      mtie_q   <= mtie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (csr_new[31:0]),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instr_retire),
    .wr_lo_i (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (csr_new[31:0]),
    .count_o (minstret)
  );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios followed by
// randomized traffic, all compared against an architectural model.
module tb_csr_trap_ctrl;

  localparam logic [31:0] RST_VEC = 32'h0000_0200;

  localparam int RUNNING   = 0;
  localparam int ASLEEP    = 1;
  localparam int TO_VECTOR = 2;
  localparam int TO_EPC    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_read = 1'b0, csr_write = 1'b0, flag_mret = 1'b0, wfi_stall = 1'b0;
  logic [1:0]  csr_imm_sel = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = '0, pc_ex = '0;
  logic        instr_retire = 1'b0, stall_in = 1'b0, ext_irq = 1'b0, timer_irq = 1'b0;
  logic [31:0] csr_rdata, redirect_pc;
  logic        interrupt, redirect, flush, pipe_stall;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .csr_read(csr_read), .csr_write(csr_write),
    .csr_imm_sel(csr_imm_sel), .flag_mret(flag_mret), .wfi_stall(wfi_stall),
    .funct3(funct3), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .pc_ex(pc_ex),
    .instr_retire(instr_retire), .stall_in(stall_in), .ext_irq(ext_irq),
    .timer_irq(timer_irq), .csr_rdata(csr_rdata), .interrupt(interrupt),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .pipe_stall(pipe_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model
  bit          model_valid = 0;
  logic        m_mie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;
  int          m_mode;

  logic [31:0] obs_rdata, obs_rpc;
  logic        obs_redirect, obs_flush, obs_stall;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h304: return (m_meie ? 32'h800 : 32'h0) | (m_mtie ? 32'h80 : 32'h0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_pending();
    return (ext_irq && m_meie) || (timer_irq && m_mtie);
  endfunction

  task automatic m_enter_trap(input logic [31:0] epc);
    m_mcause = (ext_irq && m_meie) ? 32'h8000_000B : 32'h8000_0007;
    m_mepc   = epc & 32'hFFFF_FFFC;
    m_mpie   = m_mie;
    m_mie    = 1'b0;
    m_mode   = TO_VECTOR;
  endtask

  task automatic model_update();
    logic [31:0] old_v, new_v;
    logic [63:0] cyc_n, ret_n;
    logic        trapped, wr_ok;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
      m_mtvec = RST_VEC & 32'hFFFF_FFFC; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ret = 0; m_mode = RUNNING; model_valid = 1;
      return;
    end
    if (!model_valid) return;
    old_v   = m_read(csr_addr);
    cyc_n   = m_cyc + 64'd1;
    ret_n   = m_ret + (instr_retire ? 64'd1 : 64'd0);
    trapped = 0;
    wr_ok   = 0;
    case (m_mode)
      RUNNING: if (!stall_in) begin
        if (m_pending() && m_mie && !flag_mret) begin
          m_enter_trap(pc_ex);
          trapped = 1;
        end else if (flag_mret) begin
          m_mie = m_mpie; m_mpie = 1; m_mode = TO_EPC;
        end else if (wfi_stall) begin
          m_mode = ASLEEP;
        end
        wr_ok = csr_write && !trapped && (funct3[1:0] != 2'b00);
      end
      ASLEEP: if (m_pending()) begin
        if (m_mie) m_enter_trap(pc_ex + 32'd4);
        else m_mode = RUNNING;
      end
      default: m_mode = RUNNING;
    endcase
    if (wr_ok) begin
      case (funct3[1:0])
        2'b01:   new_v = csr_wdata;
        2'b10:   new_v = old_v | csr_wdata;
        default: new_v = old_v & ~csr_wdata;
      endcase
      case (csr_addr)
        12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
        12'h304: begin m_meie = new_v[11]; m_mtie = new_v[7]; end
        12'h305: m_mtvec  = new_v & 32'hFFFF_FFFC;
        12'h341: m_mepc   = new_v & 32'hFFFF_FFFC;
        12'h342: m_mcause = new_v;
        12'hB00: cyc_n = {m_cyc[63:32], new_v};
        12'hB80: cyc_n = {new_v, m_cyc[31:0]};
        12'hB02: ret_n = {m_ret[63:32], new_v};
        12'hB82: ret_n = {new_v, m_ret[31:0]};
        default: ;
      endcase
    end
    m_cyc = cyc_n;
    m_ret = ret_n;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    if (model_valid) begin
      check("interrupt", interrupt, m_pending());
      check("redirect", redirect, (m_mode == TO_VECTOR) || (m_mode == TO_EPC));
      check("flush", flush, (m_mode == TO_VECTOR) || (m_mode == TO_EPC));
      check("pipe_stall", pipe_stall, m_mode == ASLEEP);
      if (m_mode == TO_VECTOR) check("redirect_pc_vec", redirect_pc, m_mtvec);
      if (m_mode == TO_EPC)    check("redirect_pc_epc", redirect_pc, m_mepc);
      if (csr_read) check($sformatf("rdata_%h", csr_addr), csr_rdata, m_read(csr_addr));
    end
    obs_rdata    = csr_rdata;
    obs_rpc      = redirect_pc;
    obs_redirect = redirect;
    obs_flush    = flush;
    obs_stall    = pipe_stall;
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    csr_read = 0; csr_write = 0; flag_mret = 0; wfi_stall = 0; stall_in = 0;
    funct3 = 3'b000; csr_addr = 12'h000; csr_wdata = '0; instr_retire = 0;
  endtask

  task automatic csr_access(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] wd);
    set_idle();
    csr_read = 1; csr_write = (f3 != 3'b000); funct3 = f3; csr_addr = a; csr_wdata = wd;
    tick();
    set_idle();
  endtask

  int stall_cnt, redir_cnt, r;
  logic [11:0] addr_tbl [14] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h301, 12'h7C0,
                                 12'h300, 12'h304};

  initial begin
    @(negedge clk);
    rst_n = 0; tick(); tick();
    rst_n = 1; set_idle(); tick();

    // Reset values
    csr_access(12'h305, 3'b000, 0); check("rst_mtvec", obs_rdata, RST_VEC);
    csr_access(12'h300, 3'b000, 0); check("rst_mstatus", obs_rdata, 32'h0000_1800);
    csr_access(12'hB00, 3'b000, 0); check("rst_mcycle_small", obs_rdata < 32'd16, 1'b1);

    // Read-modify-write ops return the old value
    csr_access(12'h305, 3'b001, 32'h100); check("rw_mtvec_old", obs_rdata, RST_VEC);
    csr_access(12'h300, 3'b010, 32'h8);   check("rs_mstatus_old", obs_rdata, 32'h1800);
    csr_access(12'h300, 3'b011, 32'h8);   check("rc_mstatus_old", obs_rdata, 32'h1808);
    csr_access(12'h300, 3'b000, 0);       check("mstatus_mie0", obs_rdata, 32'h1800);
    csr_access(12'h305, 3'b001, 32'h103); check("mtvec_100", obs_rdata, 32'h100);
    csr_access(12'h305, 3'b000, 0);       check("mtvec_masked", obs_rdata, 32'h100);

    // External interrupt entry
    csr_access(12'h300, 3'b010, 32'h8);
    csr_access(12'h304, 3'b001, 32'h800);
    pc_ex = 32'h40; ext_irq = 1; tick();
    ext_irq = 0; tick();
    check("ext_redirect", obs_redirect, 1'b1);
    check("ext_flush", obs_flush, 1'b1);
    check("ext_target", obs_rpc, 32'h100);
    csr_access(12'h341, 3'b000, 0); check("ext_mepc", obs_rdata, 32'h40);
    csr_access(12'h342, 3'b000, 0); check("ext_mcause", obs_rdata, 32'h8000_000B);
    csr_access(12'h300, 3'b000, 0); check("ext_mstatus", obs_rdata, 32'h1880);

    // Both pending: external wins; then MRET
    csr_access(12'h304, 3'b001, 32'h880);
    ext_irq = 1; timer_irq = 1; tick();
    csr_access(12'h300, 3'b010, 32'h8);
    tick();
    ext_irq = 0; timer_irq = 0; tick();
    csr_access(12'h342, 3'b000, 0); check("both_mcause", obs_rdata, 32'h8000_000B);
    flag_mret = 1; tick();
    flag_mret = 0; tick();
    check("mret_redirect", obs_redirect, 1'b1);
    check("mret_target", obs_rpc, 32'h40);
    csr_access(12'h300, 3'b000, 0); check("mret_mstatus", obs_rdata, 32'h1888);

    // WFI with MIE=0: wake without trap
    csr_access(12'h300, 3'b011, 32'h8);
    csr_access(12'h304, 3'b001, 32'h80);
    pc_ex = 32'h80; wfi_stall = 1; tick();
    stall_cnt = 0;
    for (int i = 0; i < 9; i++) begin tick(); stall_cnt += int'(obs_stall); end
    timer_irq = 1; wfi_stall = 0; tick(); stall_cnt += int'(obs_stall);
    check("wfi_stall_cycles", stall_cnt, 10);
    tick();
    check("wfi_wake_stall", obs_stall, 1'b0);
    check("wfi_wake_noredir", obs_redirect, 1'b0);
    timer_irq = 0; tick();

    // WFI with MIE=1: trap returns past the WFI
    csr_access(12'h300, 3'b010, 32'h8);
    pc_ex = 32'h80; wfi_stall = 1; tick();
    for (int i = 0; i < 9; i++) tick();
    timer_irq = 1; wfi_stall = 0; tick();
    timer_irq = 0; tick();
    check("wfi_trap_redirect", obs_redirect, 1'b1);
    csr_access(12'h341, 3'b000, 0); check("wfi_mepc", obs_rdata, 32'h84);
    csr_access(12'h342, 3'b000, 0); check("wfi_mcause", obs_rdata, 32'h8000_0007);

    // Reset while asleep
    wfi_stall = 1; tick(); tick();
    check("sleep_before_rst", obs_stall, 1'b1);
    rst_n = 0; tick();
    rst_n = 1; wfi_stall = 0; tick();
    check("rst_wakes", obs_stall, 1'b0);
    csr_access(12'h305, 3'b000, 0); check("rst2_mtvec", obs_rdata, RST_VEC);

    // mcycle carry across halves
    csr_access(12'hB00, 3'b001, 32'hFFFF_FFFF);
    csr_access(12'hB80, 3'b001, 32'h0);
    tick();
    csr_access(12'hB80, 3'b000, 0); check("mcycleh_carry", obs_rdata, 32'h1);

    // stall_in holds off a pending interrupt
    csr_access(12'h300, 3'b010, 32'h8);
    csr_access(12'h304, 3'b001, 32'h800);
    ext_irq = 1; stall_in = 1; redir_cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); redir_cnt += int'(obs_redirect); end
    stall_in = 0; tick(); redir_cnt += int'(obs_redirect);
    check("stall_no_trap", redir_cnt, 0);
    ext_irq = 0; tick();
    check("stall_release_trap", obs_redirect, 1'b1);
    check("stall_release_target", obs_rpc, RST_VEC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_idle();
      rst_n        = ($urandom_range(0, 299) != 0);
      stall_in     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 19) == 0) timer_irq = ~timer_irq;
      r = $urandom_range(0, 9);
      if (r == 0) flag_mret = 1;
      else if (r == 1) wfi_stall = 1;
      else if (r <= 6) csr_write = 1;
      csr_read     = csr_write | $urandom_range(0, 1) == 1;
      csr_addr     = addr_tbl[$urandom_range(0, 13)];
      funct3       = 3'($urandom_range(0, 7));
      csr_wdata    = $urandom;
      pc_ex        = $urandom & 32'hFFFF_FFFC;
      instr_retire = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
